// File: rtl/frequency_marker_generator_pkg.sv
// frequency_marker_pkg: frequency codes, line FSM encoding and period lookup shared with the detector
package frequency_marker_pkg;
    localparam logic [1:0] FREQUENCY_1    = 2'b00;
    localparam logic [1:0] FREQUENCY_2    = 2'b01;
    localparam logic [1:0] FREQUENCY_3    = 2'b10;
    localparam logic [1:0] FREQUENCY_KEEP = 2'b11;
    typedef enum logic {BLANK = 1'b0, ACTIVE = 1'b1} line_state_t;
    function automatic logic [31:0] period_select(
        input logic [1:0]  code,
        input logic [31:0] p1,
        input logic [31:0] p2,
        input logic [31:0] p3
    );
        return code == FREQUENCY_2 ? p2 : code == FREQUENCY_3 ? p3 : p1;
    endfunction
endpackage

// File: rtl/frequency_marker_generator_line_timing.sv
// line_timing_generator: ACTIVE/BLANK line framing with pixel column and enable-hold
module line_timing_generator
    import frequency_marker_pkg::*;
#(
    parameter int line_length  = 16,
    parameter int blank_length = 4
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        enable,
    output logic        active_cycle,
    output logic [11:0] column,
    output logic        lval
);
    localparam logic [11:0] LINE_LAST  = 12'(line_length - 1);
    localparam logic [11:0] BLANK_LAST = 12'(blank_length - 1);
    line_state_t state, state_next;
    logic [11:0] blank_counter, blank_next, pixel_counter, pixel_next;
    assign active_cycle = enable && state == ACTIVE;
    assign column = pixel_counter;
    // state and counters advance only while enabled; lval trails the state by one cycle
    always_ff @(posedge pixel_clock) begin
        if (!reset) begin
            state         <= BLANK;
            blank_counter <= '0;
            pixel_counter <= '0;
            lval          <= 1'b0;
        end else begin
            state         <= state_next;
            blank_counter <= blank_next;
            pixel_counter <= pixel_next;
            lval          <= active_cycle;
        end
    end
    // next line position: count out the blank gap, then walk the active columns
    always_comb begin
        state_next = state;
        blank_next = blank_counter;
        pixel_next = pixel_counter;
        if (enable && state == BLANK) begin
            state_next = blank_counter == BLANK_LAST ? ACTIVE : BLANK;
            blank_next = blank_counter == BLANK_LAST ? '0 : blank_counter + 12'd1;
            pixel_next = '0;
        end else if (enable) begin
            state_next = pixel_counter == LINE_LAST ? BLANK : ACTIVE;
            pixel_next = pixel_counter == LINE_LAST ? '0 : pixel_counter + 12'd1;
        end
    end
endmodule

// File: rtl/frequency_marker_generator.sv
// frequency_marker_generator: line-scan source whose marker spacing encodes a selectable period
module frequency_marker_generator
    import frequency_marker_pkg::*;
#(
    parameter int          line_length      = 16,
    parameter int          blank_length     = 4,
    parameter int          pixel_number     = 5,
    parameter logic [31:0] period_1         = 640,
    parameter logic [31:0] period_2         = 960,
    parameter logic [31:0] period_3         = 1280,
    parameter logic [31:0] clock_period_ns  = 20,
    parameter logic [7:0]  marker_value     = 8'hFF,
    parameter logic [7:0]  background_value = 8'h00
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] freq_sel,
    output logic       lval,
    output logic [7:0] pixel,
    output logic       marker,
    output logic       jump_sent,
    output logic [1:0] current_frequency
);
    logic        active_cycle, marker_cycle, new_code, first, jump_pending;
    logic [11:0] column;
    logic [31:0] timer, timer_inc;
    logic [32:0] timer_sum;
    line_timing_generator #(
        .line_length (line_length),
        .blank_length(blank_length)
    ) u_line_timing (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .enable      (enable),
        .active_cycle(active_cycle),
        .column      (column),
        .lval        (lval)
    );
    assign timer_sum    = {1'b0, timer} + {1'b0, clock_period_ns};
    assign timer_inc    = timer_sum[32] ? '1 : timer_sum[31:0];
    assign marker_cycle = active_cycle && column == 12'(pixel_number) &&
                          (first || timer >= period_select(current_frequency, period_1, period_2, period_3));
    assign new_code     = freq_sel != FREQUENCY_KEEP && freq_sel != current_frequency;
    // marker emission, interval timing and frequency switching at marker boundaries
    always_ff @(posedge pixel_clock) begin
        if (!reset) begin
            pixel             <= '0;
            marker            <= 1'b0;
            jump_sent         <= 1'b0;
            current_frequency <= FREQUENCY_1;
            timer             <= '0;
            first             <= 1'b1;
            jump_pending      <= 1'b0;
        end else begin
            pixel     <= active_cycle ? (marker_cycle ? marker_value : background_value) : 8'h00;
            marker    <= marker_cycle;
            jump_sent <= marker_cycle && jump_pending;
            if (active_cycle) timer <= marker_cycle ? clock_period_ns : timer_inc;
            if (marker_cycle) begin
                first        <= 1'b0;
                jump_pending <= new_code;
                if (new_code) current_frequency <= freq_sel;
            end
        end
    end
endmodule

// File: tb/tb_frequency_marker_generator.sv
// tb_frequency_marker_generator: randomized scoreboard check against a line-position reference model
module tb_frequency_marker_generator;
    typedef struct {
        logic       lval;
        logic [7:0] pixel;
        logic       marker;
        logic       jump;
        logic [1:0] freq;
    } exp_t;
    logic       pixel_clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [1:0] freq_sel = 2'd0;
    logic       lval, marker, jump_sent;
    logic [7:0] pixel;
    logic [1:0] current_frequency;
    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         n, act, last_mk, freq;
    bit         first, pend;
    frequency_marker_generator dut (
        .pixel_clock      (pixel_clock),
        .reset            (reset),
        .enable           (enable),
        .freq_sel         (freq_sel),
        .lval             (lval),
        .pixel            (pixel),
        .marker           (marker),
        .jump_sent        (jump_sent),
        .current_frequency(current_frequency)
    );
    always #5 pixel_clock = ~pixel_clock;
    function automatic int period_of(input int code);
        return code == 1 ? 960 : code == 2 ? 1280 : 640;
    endfunction
    // predict the output seen after the coming edge: lines are 4 blank + 16 active enabled cycles
    task automatic model_step();
        exp_t e;
        int   pos, col;
        bit   mk;
        e = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
        if (!reset) begin
            n = 0; act = 0; last_mk = 0; freq = 0; first = 1; pend = 0;
        end else if (enable) begin
            pos = n % 20;
            if (pos >= 4) begin
                col = pos - 4;
                mk  = col == 5 && (first || 20 * (act - last_mk) >= period_of(freq));
                e.lval   = 1'b1;
                e.pixel  = mk ? 8'hFF : 8'h00;
                e.marker = mk;
                e.jump   = mk && pend;
                if (mk) begin
                    first   = 0;
                    last_mk = act;
                    pend    = 0;
                    if (freq_sel != 2'd3 && int'(freq_sel) != freq) begin
                        freq = int'(freq_sel);
                        pend = 1;
                    end
                end
                act++;
            end
            n++;
        end
        e.freq = 2'(freq);
        q.push_back(e);
    endtask
    initial begin
        int gap = 0;
        for (int i = 0; i < 8000; i++) begin
            reset = i < 3 ? 1'b0 : ($urandom_range(0, 1499) != 0);
            if (gap > 0) gap--;
            else if (i > 600 && $urandom_range(0, 59) == 0) gap = $urandom_range(1, 8);
            enable = gap == 0;
            if (i > 600 && $urandom_range(0, 39) == 0) freq_sel = 2'($urandom_range(0, 3));
            model_step();
            @(negedge pixel_clock);
        end
        repeat (3) @(negedge pixel_clock);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected outputs never observed, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    // monitor: pop one prediction per clock and compare it with the registered outputs
    initial begin
        exp_t e;
        forever begin
            @(posedge pixel_clock);
            #1;
            if (q.size() == 0) begin
                if (vectors < 8000) begin
                    miscompares++;
                    $display("FAIL underflow: output at %0t with no prediction", $time);
                end
            end else begin
                e = q.pop_front();
                vectors++;
                if (lval !== e.lval) begin
                    miscompares++;
                    $display("FAIL lval @%0t: got %b expected %b", $time, lval, e.lval);
                end
                if (pixel !== e.pixel) begin
                    miscompares++;
                    $display("FAIL pixel @%0t: got %h expected %h", $time, pixel, e.pixel);
                end
                if (marker !== e.marker) begin
                    miscompares++;
                    $display("FAIL marker @%0t: got %b expected %b", $time, marker, e.marker);
                end
                if (jump_sent !== e.jump) begin
                    miscompares++;
                    $display("FAIL jump_sent @%0t: got %b expected %b", $time, jump_sent, e.jump);
                end
                if (current_frequency !== e.freq) begin
                    miscompares++;
                    $display("FAIL current_frequency @%0t: got %0d expected %0d", $time, current_frequency, e.freq);
                end
            end
        end
    end
endmodule
